// File: rtl/linebuf_port_arbiter.sv
// linebuf_port_arbiter
//   Shares one single-port scanline RAM between the TIA pixel writer and the
//   VGA scanout reader. Reads are latency-critical and win arbitration; writes
//   are queued in a small FIFO and drained in idle slots. A read-streak limit
//   forces a FIFO drain so the writer cannot starve.
//
// Ports
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   wr_valid/wr_ready       TIA write handshake (wr_ready = FIFO not full)
//   wr_addr, wr_data        write address / colour index
//   rd_req/rd_ready         VGA read request (held) / grant this cycle
//   rd_addr                 read address
//   rd_valid, rd_data       registered read return, valid two cycles after grant
//   mem_en, mem_we          RAM access strobe / write select
//   mem_addr, mem_wdata     RAM address / write data (FIFO head)
//   mem_rdata               RAM read data, one cycle after a read access
//   stat_stalls             count of refused reads during forced writes
//
// Build option
//   LINEBUF_ARB_STATS_EN    when defined, builds the saturating stall counter;
//                           otherwise stat_stalls is tied to zero.

module linebuf_port_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 7,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_RD_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_stalls
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int STK_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [PTR_W:0]   PTR_ONE    = 1;
  localparam logic [STK_W-1:0] STK_ONE    = 1;
  localparam logic [STK_W-1:0] STK_MAX    = STK_W'(MAX_RD_STREAK);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } gnt_e;

  // Write FIFO; pointers carry an extra MSB to tell full from empty.
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [STK_W-1:0]  r_streak;
  logic              r_rd_pend;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_empty;
  logic              w_full;
  logic              w_force_wr;
  logic              w_push;
  logic              w_pop;
  gnt_e              w_gnt;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head_addr = r_fifo_addr[r_rd_ptr[PTR_W-1:0]];
  assign w_head_data = r_fifo_data[r_rd_ptr[PTR_W-1:0]];
  assign w_force_wr  = !w_empty && (r_streak == STK_MAX);

  // Full depends on registered pointers only, so a popping full FIFO still
  // refuses the push; rst_n gating keeps the handshake closed during reset.
  assign wr_ready = rst_n && !w_full;
  assign w_push   = wr_valid && wr_ready;
  assign w_pop    = (w_gnt == GNT_WRITE);

  always_comb begin
    w_gnt = GNT_IDLE;
    if (!rst_n)          w_gnt = GNT_IDLE;
    else if (w_force_wr) w_gnt = GNT_WRITE;
    else if (rd_req)     w_gnt = GNT_READ;
    else if (!w_empty)   w_gnt = GNT_WRITE;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_ready  = 1'b0;
    case (w_gnt)
      GNT_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_head_addr;
        mem_wdata = w_head_data;
      end
      GNT_READ: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
        rd_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= wr_addr;
      r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_pop || w_empty) begin
      r_streak <= '0;
    end else if ((w_gnt == GNT_READ) && (r_streak != STK_MAX)) begin
      r_streak <= r_streak + STK_ONE;
    end
  end

  // Grant -> RAM data next cycle -> registered return the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= (w_gnt == GNT_READ);
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= mem_rdata;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

`ifdef LINEBUF_ARB_STATS_EN
  logic [15:0] r_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stalls <= '0;
    end else if (w_force_wr && rd_req && (r_stalls != 16'hFFFF)) begin
      r_stalls <= r_stalls + 16'd1;
    end
  end

  assign stat_stalls = r_stalls;
`else
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_linebuf_port_arbiter.sv
// Testbench for linebuf_port_arbiter: directed scenarios with a scoreboard of
// expected RAM accesses and read returns, checked by a negedge monitor.
module tb_linebuf_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;
  logic       rd_req, rd_ready;
  logic [7:0] rd_addr;
  logic       rd_valid;
  logic [6:0] rd_data;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr;
  logic [6:0] mem_wdata;
  logic [6:0] mem_rdata = '0;
  logic [15:0] stat_stalls;

  always #5 clk = ~clk;

  linebuf_port_arbiter #(
    .ADDR_W(8), .DATA_W(7), .FIFO_DEPTH(4), .MAX_RD_STREAK(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_stalls(stat_stalls)
  );

  // Single-port RAM with one-cycle read latency.
  logic [6:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [6:0] data;
  } acc_t;

  acc_t       exp_acc [$];
  logic [6:0] exp_rd  [$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_r(input logic [7:0] a, input logic [6:0] d, input logic ret);
    exp_acc.push_back('{we: 1'b0, addr: a, data: 7'h00});
    if (ret) exp_rd.push_back(d);
  endtask

  task automatic exp_w(input logic [7:0] a, input logic [6:0] d);
    exp_acc.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic step(input logic rd, input logic [7:0] ra, input logic wv,
                      input logic [7:0] wa, input logic [6:0] wd);
    @(posedge clk);
    #1;
    rd_req = rd; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1;
  endtask

  // Monitor: compare every RAM access and every read return against the queues.
  acc_t       m_acc;
  logic [6:0] m_rd;
  always @(negedge clk) begin
    if (mem_en) begin
      if (exp_acc.size() == 0) begin
        n_total++;
        $display("FAIL mem_unexpected: got we=%0b addr=0x%0h, want no access at %0t",
                 mem_we, mem_addr, $time);
      end else begin
        m_acc = exp_acc.pop_front();
        chk("mem_we", {31'd0, mem_we}, {31'd0, m_acc.we});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, m_acc.addr});
        if (m_acc.we) chk("mem_wdata", {25'd0, mem_wdata}, {25'd0, m_acc.data});
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got rd_data=0x%0h, want no rd_valid at %0t", rd_data, $time);
      end else begin
        m_rd = exp_rd.pop_front();
        chk("rd_data", {25'd0, rd_data}, {25'd0, m_rd});
      end
    end
  end

  function automatic logic [6:0] ld(input int unsigned a);
    return 7'(7'h11 + a);
  endfunction

  logic [15:0] exp_stat;

  initial begin
    rst_n = 1'b0;
    rd_req = 1'b1; rd_addr = '0; wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
    #12;
    chk("rst_wr_ready", {31'd0, wr_ready}, 0);
    chk("rst_rd_ready", {31'd0, rd_ready}, 0);
    chk("rst_mem_en",   {31'd0, mem_en}, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_rd_data",  {25'd0, rd_data}, 0);
    chk("rst_stat",     {16'd0, stat_stalls}, 0);
    rd_req = 1'b0; wr_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; #1;
    chk("post_rst_wr_ready", {31'd0, wr_ready}, 1);

    // 1: writes only, drained one cycle after each push
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 8'(i), ld(i));
      chk("s1_wr_ready", {31'd0, wr_ready}, 1);
      exp_w(8'(i), ld(i));
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
    chk("s1_idle_mem_en",    {31'd0, mem_en}, 0);
    chk("s1_idle_mem_addr",  {24'd0, mem_addr}, 0);
    chk("s1_idle_mem_wdata", {25'd0, mem_wdata}, 0);

    // 2: reads only
    step(1'b0, 8'h00, 1'b1, 8'h10, 7'h2A);
    exp_w(8'h10, 7'h2A);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
    step(1'b1, 8'h10, 1'b0, 8'h00, 7'h00);
    chk("s2_rd_ready", {31'd0, rd_ready}, 1);
    exp_r(8'h10, 7'h2A, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
    chk("s2_lat_t1", {31'd0, rd_valid}, 0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
    chk("s2_lat_t2", {31'd0, rd_valid}, 1);
    chk("s2_lat_data", {25'd0, rd_data}, 32'h2A);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
    chk("s2_pulse_end", {31'd0, rd_valid}, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      step(1'b1, 8'(i % 4), 1'b0, 8'h00, 7'h00);
      chk("s2_b2b_rd_ready", {31'd0, rd_ready}, 1);
      if (i >= 2) chk("s2_b2b_rd_valid", {31'd0, rd_valid}, 1);
      exp_r(8'(i % 4), ld(i % 4), 1'b1);
    end
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);

    // 3: contention, rd_req held; writes forced at cycles 4 and 8
    for (int unsigned c = 0; c < 14; c++) begin
      step(1'b1, 8'(c % 4), (c < 2), 8'(8'h80 + c), 7'(7'h21 + c));
      if (c == 4) begin
        chk("s3_force_rd_ready", {31'd0, rd_ready}, 0);
        exp_w(8'h80, 7'h21);
      end else if (c == 8) begin
        chk("s3_force_rd_ready", {31'd0, rd_ready}, 0);
        exp_w(8'h81, 7'h22);
      end else begin
        chk("s3_rd_ready", {31'd0, rd_ready}, 1);
        exp_r(8'(c % 4), ld(c % 4), 1'b1);
      end
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
`ifdef LINEBUF_ARB_STATS_EN
    exp_stat = 16'd2;
`else
    exp_stat = 16'd0;
`endif
    chk("s3_stat_stalls", {16'd0, stat_stalls}, {16'd0, exp_stat});
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);

    // 4: fill FIFO under reads; full rejects even on the forced-pop cycle
    for (int unsigned d = 0; d < 7; d++) begin
      step(1'b1, 8'(d % 4), 1'b1, 8'(8'h90 + d), 7'(7'h30 + d));
      chk("s4_wr_ready", {31'd0, wr_ready}, (d == 4 || d == 6) ? 32'd0 : 32'd1);
      chk("s4_rd_ready", {31'd0, rd_ready}, (d == 4) ? 32'd0 : 32'd1);
      if (d == 4) exp_w(8'h90, 7'h30);
      else        exp_r(8'(d % 4), ld(d % 4), 1'b1);
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00); exp_w(8'h91, 7'h31);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00); exp_w(8'h92, 7'h32);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00); exp_w(8'h93, 7'h33);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00); exp_w(8'h95, 7'h35);
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
    chk("s4_drained", {31'd0, mem_en}, 0);
    exp_stat = (exp_stat == 16'd0) ? 16'd0 : 16'd3;
    chk("s4_stat_stalls", {16'd0, stat_stalls}, {16'd0, exp_stat});
    step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);

    // 5: reset with 3 queued entries and reads in flight
    step(1'b1, 8'h00, 1'b1, 8'hA0, 7'h40); exp_r(8'h00, ld(0), 1'b1);
    step(1'b1, 8'h01, 1'b1, 8'hA1, 7'h41); exp_r(8'h01, ld(1), 1'b1);
    step(1'b1, 8'h02, 1'b1, 8'hA2, 7'h42); exp_r(8'h02, ld(2), 1'b0);
    step(1'b1, 8'h03, 1'b0, 8'h00, 7'h00); exp_r(8'h03, ld(3), 1'b0);
    chk("s5_rd_ready", {31'd0, rd_ready}, 1);
    @(posedge clk); #1 rst_n = 1'b0; #1;
    chk("s5_rst_mem_en",   {31'd0, mem_en}, 0);
    chk("s5_rst_mem_addr", {24'd0, mem_addr}, 0);
    chk("s5_rst_rd_ready", {31'd0, rd_ready}, 0);
    chk("s5_rst_wr_ready", {31'd0, wr_ready}, 0);
    chk("s5_rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("s5_rst_rd_data",  {25'd0, rd_data}, 0);
    chk("s5_rst_stat",     {16'd0, stat_stalls}, 0);
    rd_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; #1;
    chk("s5_rel_wr_ready", {31'd0, wr_ready}, 1);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 7'h00);
      chk("s5_fifo_empty", {31'd0, mem_en}, 0);
    end

    chk("end_acc_queue", exp_acc.size(), 0);
    chk("end_rd_queue",  exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
